// File: rtl/logic_exec_stage.sv
// logic_exec_stage
// Registered execute stage for the MIPS logical ops (AND/OR/XOR/NOR).
// Valid/ready on both sides with a two-entry (main + skid) buffer so a
// downstream stall never drops a result. Each result carries its
// destination register tag; writes to $zero (tag 0) always yield 0.
// Optional feature macro: LOGIC_ZERO_FLAG_EN adds the out_zero port and a
// per-entry zero flag that travels with the result.
module logic_exec_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic [TAG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
`ifdef LOGIC_ZERO_FLAG_EN
    output logic              out_zero,
`endif
    output logic [TAG_W-1:0]  out_rd
);

    // Occupancy encoding {main valid, skid valid}; 01 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    // Bitwise logical result; a $zero destination forces the value to 0.
    function automatic logic [DATA_W-1:0] f_logic_op(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y,
        input logic [TAG_W-1:0]  rd
    );
        logic [DATA_W-1:0] res;
        case (op)
            2'b00:   res = x & y;
            2'b01:   res = x | y;
            2'b10:   res = x ^ y;
            2'b11:   res = ~(x | y);
            default: res = {DATA_W{1'b0}};
        endcase
        if (rd == {TAG_W{1'b0}}) begin
            res = {DATA_W{1'b0}};
        end else begin
            res = res;
        end
        return res;
    endfunction

    // Stored state
    logic              r_main_valid;
    logic              r_skid_valid;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_res;
    logic [TAG_W-1:0]  r_main_rd;
    logic [DATA_W-1:0] r_skid_res;
    logic [TAG_W-1:0]  r_skid_rd;

    // Next-state values
    logic              w_main_valid_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_main_res_nxt;
    logic [TAG_W-1:0]  w_main_rd_nxt;
    logic [DATA_W-1:0] w_skid_res_nxt;
    logic [TAG_W-1:0]  w_skid_rd_nxt;

    logic              w_accept;
    logic              w_drain;
    logic [1:0]        w_state;
    logic [DATA_W-1:0] w_new_res;

`ifdef LOGIC_ZERO_FLAG_EN
    logic r_main_zero;
    logic r_skid_zero;
    logic w_main_zero_nxt;
    logic w_skid_zero_nxt;
    logic w_new_zero;
    assign w_new_zero = (w_new_res == {DATA_W{1'b0}});
    assign out_zero   = r_main_zero;
`endif

    assign w_accept  = in_valid & r_in_ready;
    assign w_drain   = r_main_valid & out_ready;
    assign w_state   = {r_main_valid, r_skid_valid};
    assign w_new_res = f_logic_op(in_op, in_x, in_y, in_rd);

    assign out_valid  = r_main_valid;
    assign out_result = r_main_res;
    assign out_rd     = r_main_rd;
    assign in_ready   = r_in_ready;

    // Occupancy transitions: load main/skid on accept, shift skid on drain, flush empties.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_main_res_nxt   = r_main_res;
        w_main_rd_nxt    = r_main_rd;
        w_skid_res_nxt   = r_skid_res;
        w_skid_rd_nxt    = r_skid_rd;
`ifdef LOGIC_ZERO_FLAG_EN
        w_main_zero_nxt  = r_main_zero;
        w_skid_zero_nxt  = r_skid_zero;
`endif
        if (flush) begin
            // Payload registers keep their last value; only occupancy is cleared.
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else begin
            case (w_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_valid_nxt = 1'b1;
                        w_main_res_nxt   = w_new_res;
                        w_main_rd_nxt    = in_rd;
`ifdef LOGIC_ZERO_FLAG_EN
                        w_main_zero_nxt  = w_new_zero;
`endif
                    end else begin
                        w_main_valid_nxt = 1'b0;
                    end
                end
                ST_ONE: begin
                    case ({w_accept, w_drain})
                        2'b11: begin
                            // Old result leaves, new one takes its place.
                            w_main_res_nxt = w_new_res;
                            w_main_rd_nxt  = in_rd;
`ifdef LOGIC_ZERO_FLAG_EN
                            w_main_zero_nxt = w_new_zero;
`endif
                        end
                        2'b10: begin
                            // Downstream stalled: park the new result in the skid entry.
                            w_skid_valid_nxt = 1'b1;
                            w_skid_res_nxt   = w_new_res;
                            w_skid_rd_nxt    = in_rd;
`ifdef LOGIC_ZERO_FLAG_EN
                            w_skid_zero_nxt  = w_new_zero;
`endif
                        end
                        2'b01: begin
                            w_main_valid_nxt = 1'b0;
                        end
                        default: begin
                            w_main_valid_nxt = r_main_valid;
                        end
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_drain) begin
                        w_skid_valid_nxt = 1'b0;
                        w_main_res_nxt   = r_skid_res;
                        w_main_rd_nxt    = r_skid_rd;
`ifdef LOGIC_ZERO_FLAG_EN
                        w_main_zero_nxt  = r_skid_zero;
`endif
                    end else begin
                        w_skid_valid_nxt = r_skid_valid;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to empty.
                    w_main_valid_nxt = 1'b0;
                    w_skid_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset to the empty, ready condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main_res   <= {DATA_W{1'b0}};
            r_main_rd    <= {TAG_W{1'b0}};
            r_skid_res   <= {DATA_W{1'b0}};
            r_skid_rd    <= {TAG_W{1'b0}};
`ifdef LOGIC_ZERO_FLAG_EN
            r_main_zero  <= 1'b1;
            r_skid_zero  <= 1'b1;
`endif
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
            r_main_res   <= w_main_res_nxt;
            r_main_rd    <= w_main_rd_nxt;
            r_skid_res   <= w_skid_res_nxt;
            r_skid_rd    <= w_skid_rd_nxt;
`ifdef LOGIC_ZERO_FLAG_EN
            r_main_zero  <= w_main_zero_nxt;
            r_skid_zero  <= w_skid_zero_nxt;
`endif
        end
    end

endmodule
